// File: rtl/pb_event_ctrl.sv
// pb_event_ctrl: push-button event/interrupt controller.
// Turns press edges into sticky pending flags. Provides mask, vector and
// auto-repeat registers on the 8-bit memory-mapped I/O bus.
module pb_event_ctrl #(
    parameter logic [7:0]  BASE         = 8'hf7,
    parameter logic [15:0] REPEAT_DELAY = 16'd50000,
    parameter logic [15:0] REPEAT_RATE  = 16'd12500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    input  logic       we,
    output logic [7:0] out,
    input  logic [4:0] btn,
    output logic       irq
);

    localparam int unsigned NB = 5;
    localparam int unsigned CW = 16;
    localparam int unsigned TW = 3;

    localparam logic [7:0] A_PEND = BASE;
    localparam logic [7:0] A_MASK = 8'(BASE + 8'd1);
    localparam logic [7:0] A_VEC  = 8'(BASE + 8'd2);
    localparam logic [7:0] A_CTRL = 8'(BASE + 8'd3);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DELAY  = 2'd1;
    localparam logic [1:0] S_REPEAT = 2'd2;

    logic [NB-1:0] prev_q;
    logic [NB-1:0] pend_q;
    logic [NB-1:0] mask_q;
    logic          rep_en_q;
    logic [1:0]    state_q;
    logic [1:0]    state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [TW-1:0] trk_q;
    logic [TW-1:0] trk_d;

    logic [NB-1:0] rise_c;
    logic [NB-1:0] clr_c;
    logic [NB-1:0] rep_fire_c;
    logic [NB-1:0] pend_d;
    logic [NB-1:0] mask_d;
    logic [NB-1:0] active_c;
    logic [TW-1:0] rise_idx_c;
    logic [TW-1:0] vec_idx_c;
    logic [CW-1:0] limit_c;

    // Index of the lowest set bit; 0 when none is set.
    function automatic logic [TW-1:0] lowest_idx(input logic [NB-1:0] v);
        lowest_idx = '0;
        for (int i = NB - 1; i >= 0; i--) begin
            if (v[i]) lowest_idx = TW'(i);
        end
    endfunction

    // Edge detect, bus write decode and pending/mask next values.
    always_comb begin
        rise_c     = btn & ~prev_q;
        rise_idx_c = lowest_idx(rise_c);
        clr_c      = (we && addr == A_PEND) ? wdata[NB-1:0] : '0;
        pend_d     = (pend_q & ~clr_c) | rise_c | rep_fire_c;
        mask_d     = (we && addr == A_MASK) ? wdata[NB-1:0] : mask_q;
        active_c   = pend_q & mask_q;
        vec_idx_c  = lowest_idx(active_c);
        limit_c    = (state_q == S_DELAY) ? CW'(REPEAT_DELAY - 16'd1)
                                          : CW'(REPEAT_RATE - 16'd1);
    end

    // Auto-repeat next-state logic: track one held button and fire on schedule.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        trk_d      = trk_q;
        rep_fire_c = '0;
        case (state_q)
            S_IDLE: begin
                if (rep_en_q && rise_c != '0) begin
                    state_d = S_DELAY;
                    trk_d   = rise_idx_c;
                    cnt_d   = '0;
                end
            end
            S_DELAY, S_REPEAT: begin
                if (!rep_en_q) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (rise_c != '0) begin
                    // a fresh press retargets the repeat to the new button
                    state_d = S_DELAY;
                    trk_d   = rise_idx_c;
                    cnt_d   = '0;
                end else if (!btn[trk_q]) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == limit_c) begin
                    state_d           = S_REPEAT;
                    cnt_d             = '0;
                    rep_fire_c[trk_q] = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and register file update; buttons held through reset are absorbed into prev.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_q   <= btn;
            pend_q   <= '0;
            mask_q   <= '0;
            rep_en_q <= 1'b0;
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            trk_q    <= '0;
            irq      <= 1'b0;
        end else begin
            prev_q  <= btn;
            pend_q  <= pend_d;
            mask_q  <= mask_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            trk_q   <= trk_d;
            irq     <= |active_c;
            if (we && addr == A_CTRL) rep_en_q <= wdata[0];
        end
    end

    // Read mux; zero outside the register window so it can be OR-combined.
    always_comb begin
        out = '0;
        case (addr)
            A_PEND:  out = {3'b000, pend_q};
            A_MASK:  out = {3'b000, mask_q};
            A_VEC:   out = (active_c != '0) ? {1'b1, 4'b0000, vec_idx_c} : 8'h00;
            A_CTRL:  out = {7'b0000000, rep_en_q};
            default: out = '0;
        endcase
    end

endmodule

// File: tb/tb_pb_event_ctrl.sv
// Self-checking bench for pb_event_ctrl: directed steps plus randomized traffic,
// compared against a cycle-level reference model of the register/event rules.
module tb_pb_event_ctrl;

    localparam logic [7:0] BASE   = 8'hf7;
    localparam logic [7:0] A_PEND = 8'hf7;
    localparam logic [7:0] A_MASK = 8'hf8;
    localparam logic [7:0] A_VEC  = 8'hf9;
    localparam logic [7:0] A_CTRL = 8'hfa;
    localparam int D = 10;
    localparam int R = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       we;
    logic [7:0] out;
    logic [4:0] btn;
    logic       irq;

    always #10 clk = ~clk;

    pb_event_ctrl #(
        .BASE(BASE),
        .REPEAT_DELAY(16'd10),
        .REPEAT_RATE(16'd4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .addr(addr),
        .wdata(wdata),
        .we(we),
        .out(out),
        .btn(btn),
        .irq(irq)
    );

    // reference model state
    int         cyc;
    logic [4:0] m_pend;
    logic [4:0] m_mask;
    logic [4:0] m_prev;
    logic       m_rep;
    logic       m_irq;
    logic       m_active;
    int         m_trk;
    int         m_entry;

    int checks;
    int errors;

    function automatic int lowest(input logic [4:0] v);
        for (int i = 0; i < 5; i++) if (v[i]) return i;
        return 0;
    endfunction

    // One clock edge of the reference behaviour, from the register rules.
    task automatic model_edge(input logic r, input logic [4:0] b, input logic w,
                              input logic [7:0] a, input logic [7:0] d);
        logic [4:0] rise;
        logic [4:0] fire;
        logic [4:0] clr;
        int el;
        cyc++;
        if (!r) begin
            m_pend = '0; m_mask = '0; m_rep = 1'b0; m_irq = 1'b0;
            m_active = 1'b0; m_trk = 0; m_prev = b;
            return;
        end
        rise = b & ~m_prev;
        fire = '0;
        if (m_active && m_rep && rise == '0 && b[m_trk]) begin
            el = cyc - m_entry;
            if (el == D || (el > D && (el - D) % R == 0)) fire[m_trk] = 1'b1;
        end
        if (!m_rep) m_active = 1'b0;
        else if (rise != '0) begin
            m_active = 1'b1;
            m_trk    = lowest(rise);
            m_entry  = cyc;
        end else if (m_active && !b[m_trk]) m_active = 1'b0;
        m_irq = |(m_pend & m_mask);
        clr = (w && a == A_PEND) ? d[4:0] : 5'h00;
        m_pend = (m_pend & ~clr) | rise | fire;
        if (w && a == A_MASK) m_mask = d[4:0];
        if (w && a == A_CTRL) m_rep = d[0];
        m_prev = b;
    endtask

    function automatic logic [7:0] exp_read(input logic [7:0] a);
        logic [4:0] v;
        v = m_pend & m_mask;
        case (a)
            A_PEND:  return {3'b000, m_pend};
            A_MASK:  return {3'b000, m_mask};
            A_VEC:   return (v != '0) ? {1'b1, 4'b0000, 3'(lowest(v))} : 8'h00;
            A_CTRL:  return {7'b0000000, m_rep};
            default: return 8'h00;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic read_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
        addr = a;
        #1;
        chk(tag, out, exp);
    endtask

    // Drive one cycle, advance the model, then compare irq and every readable address.
    task automatic cycle(input logic r, input logic [4:0] b, input logic w,
                         input logic [7:0] a, input logic [7:0] d);
        rst_n = r; btn = b; we = w; addr = a; wdata = d;
        @(posedge clk);
        model_edge(r, b, w, a, d);
        #1;
        we = 1'b0;
        chk("irq", {7'b0, irq}, {7'b0, m_irq});
        for (int i = 0; i < 6; i++) begin
            addr = 8'(8'hf6 + i);
            #1;
            chk($sformatf("rd_%h", addr), out, exp_read(addr));
        end
    endtask

    int fires[$];
    int exp_off[5] = '{10, 14, 18, 22, 26};
    int p;
    int q;
    logic clr_next;
    logic [7:0] first_bits;
    int first_off;
    logic [4:0] rb;
    logic rw;
    logic rr;
    logic [7:0] ra;
    logic [7:0] rd;

    initial begin
        checks = 0; errors = 0; cyc = 0;
        m_pend = '0; m_mask = '0; m_prev = '0; m_rep = 1'b0; m_irq = 1'b0;
        m_active = 1'b0; m_trk = 0; m_entry = 0;
        rst_n = 1'b0; btn = 5'h04; we = 1'b0; addr = 8'h00; wdata = 8'h00;

        // reset with a button held: no event afterwards
        repeat (3) cycle(1'b0, 5'h04, 1'b0, 8'h00, 8'h00);
        read_chk("rst_mask", A_MASK, 8'h00);
        repeat (10) begin
            cycle(1'b1, 5'h04, 1'b0, 8'h00, 8'h00);
            read_chk("held_pend", A_PEND, 8'h00);
            chk("held_irq", {7'b0, irq}, 8'h00);
        end
        cycle(1'b1, 5'h00, 1'b0, 8'h00, 8'h00);
        cycle(1'b1, 5'h04, 1'b0, 8'h00, 8'h00);
        read_chk("repress_pend", A_PEND, 8'h04);
        cycle(1'b1, 5'h04, 1'b1, A_PEND, 8'h1f);

        // multi-press, vector and W1C
        cycle(1'b1, 5'h00, 1'b1, A_MASK, 8'h1f);
        cycle(1'b1, 5'h0a, 1'b0, 8'h00, 8'h00);
        read_chk("multi_pend", A_PEND, 8'h0a);
        chk("irq_lag", {7'b0, irq}, 8'h00);
        cycle(1'b1, 5'h0a, 1'b0, 8'h00, 8'h00);
        chk("irq_up", {7'b0, irq}, 8'h01);
        read_chk("vec81", A_VEC, 8'h81);
        cycle(1'b1, 5'h0a, 1'b1, A_PEND, 8'h02);
        read_chk("vec83", A_VEC, 8'h83);
        cycle(1'b1, 5'h0a, 1'b1, A_PEND, 8'h08);
        chk("irq_hold", {7'b0, irq}, 8'h01);
        cycle(1'b1, 5'h0a, 1'b0, 8'h00, 8'h00);
        chk("irq_drop", {7'b0, irq}, 8'h00);

        // masked pending does not interrupt until unmasked
        cycle(1'b1, 5'h00, 1'b1, A_MASK, 8'h01);
        cycle(1'b1, 5'h08, 1'b0, 8'h00, 8'h00);
        repeat (3) cycle(1'b1, 5'h08, 1'b0, 8'h00, 8'h00);
        read_chk("masked_pend", A_PEND, 8'h08);
        chk("masked_irq", {7'b0, irq}, 8'h00);
        cycle(1'b1, 5'h08, 1'b1, A_MASK, 8'h08);
        chk("unmask_lag", {7'b0, irq}, 8'h00);
        cycle(1'b1, 5'h08, 1'b0, 8'h00, 8'h00);
        chk("unmask_irq", {7'b0, irq}, 8'h01);

        // set wins over same-cycle clear
        cycle(1'b1, 5'h0a, 1'b1, A_PEND, 8'h02);
        read_chk("set_wins", A_PEND, 8'h0a);
        cycle(1'b1, 5'h00, 1'b1, A_PEND, 8'h1f);
        cycle(1'b1, 5'h00, 1'b1, A_MASK, 8'h00);

        // auto-repeat schedule on a single held button
        cycle(1'b1, 5'h00, 1'b1, A_CTRL, 8'h01);
        cycle(1'b1, 5'h10, 1'b0, 8'h00, 8'h00);
        p = cyc;
        clr_next = 1'b1;
        repeat (29) begin
            cycle(1'b1, 5'h10, clr_next, A_PEND, 8'h10);
            addr = A_PEND;
            #1;
            clr_next = out[4];
            if (out[4]) fires.push_back(cyc - p);
        end
        chk("fire_count", 8'(fires.size()), 8'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < fires.size()) chk($sformatf("fire_off%0d", i), 8'(fires[i]), 8'(exp_off[i]));
        end
        cycle(1'b1, 5'h00, 1'b1, A_PEND, 8'h1f);
        repeat (12) begin
            cycle(1'b1, 5'h00, 1'b0, 8'h00, 8'h00);
            read_chk("release_pend", A_PEND, 8'h00);
        end

        // retarget to a second press, then reset mid-repeat
        cycle(1'b1, 5'h10, 1'b0, 8'h00, 8'h00);
        p = cyc;
        cycle(1'b1, 5'h10, 1'b1, A_PEND, 8'h10);
        repeat (4) cycle(1'b1, 5'h10, 1'b0, 8'h00, 8'h00);
        cycle(1'b1, 5'h14, 1'b0, 8'h00, 8'h00);
        q = cyc;
        chk("second_press_gap", 8'(q - p), 8'd6);
        cycle(1'b1, 5'h14, 1'b1, A_PEND, 8'h04);
        first_bits = 8'h00;
        first_off = 0;
        repeat (11) begin
            cycle(1'b1, 5'h14, 1'b0, 8'h00, 8'h00);
            addr = A_PEND;
            #1;
            if (first_bits == 8'h00 && out != 8'h00) begin
                first_bits = out;
                first_off = cyc - q;
            end
        end
        chk("retarget_bits", first_bits, 8'h04);
        chk("retarget_off", 8'(first_off), 8'd10);
        cycle(1'b1, 5'h14, 1'b1, A_MASK, 8'h1f);
        cycle(1'b0, 5'h14, 1'b0, 8'h00, 8'h00);
        read_chk("rst2_pend", A_PEND, 8'h00);
        read_chk("rst2_mask", A_MASK, 8'h00);
        read_chk("rst2_ctrl", A_CTRL, 8'h00);
        chk("rst2_irq", {7'b0, irq}, 8'h00);
        repeat (15) cycle(1'b1, 5'h14, 1'b0, 8'h00, 8'h00);
        read_chk("post_rst_pend", A_PEND, 8'h00);

        // randomized traffic against the model
        rb = 5'h00;
        repeat (600) begin
            if ($urandom_range(31) == 0) rb = 5'($urandom);
            rw = ($urandom_range(3) == 0);
            ra = 8'(8'hf6 + $urandom_range(5));
            rd = 8'($urandom);
            if (ra == A_CTRL && $urandom_range(3) != 0) rd[0] = 1'b1;
            rr = ($urandom_range(199) != 0);
            cycle(rr, rb, rw, ra, rd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
